// File: rtl/debounce_fsm.sv
`default_nettype none
// ============================================================================
// Module      : debounce_fsm
// Description : Tick-qualified switch debouncer. A change on sw is accepted
//               only after it has held across STABLE_TICKS consecutive timer
//               ticks; produces a clean level plus one-cycle rise/fall strobes.
//               Optional macro DEBOUNCE_SYNC_EN adds a 2-flop input
//               synchronizer in front of the state machine.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_fsm #(
    parameter int STABLE_TICKS = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic sw,
    output logic db_level,
    output logic db_rise,
    output logic db_fall,
    output logic busy
);

    localparam int c_CNT_W = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(STABLE_TICKS - 1);

    typedef enum logic [1:0] {
        ST_ZERO  = 2'd0,
        ST_WAIT1 = 2'd1,
        ST_ONE   = 2'd2,
        ST_WAIT0 = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic                 w_sw_s;
    logic                 w_level_nxt;
    logic                 w_rise_nxt;
    logic                 w_fall_nxt;
    logic                 w_busy_nxt;

`ifdef DEBOUNCE_SYNC_EN
    logic r_sync_0;
    logic r_sync_1;

    // Two-flop synchronizer bringing the asynchronous pin into the clk domain
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_0 <= 1'b0;
            r_sync_1 <= 1'b0;
        end else begin
            r_sync_0 <= sw;
            r_sync_1 <= r_sync_0;
        end
    end

    assign w_sw_s = r_sync_1;
`else
    // Input is already synchronous to clk; use it directly
    assign w_sw_s = sw;
`endif

    // Next-state, tick counter and output decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            ST_ZERO: begin
                if (w_sw_s) begin
                    w_state_nxt = ST_WAIT1;
                    w_cnt_nxt   = '0;
                end
            end
            ST_WAIT1: begin
                // A bounce back wins over a coincident tick
                if (!w_sw_s) begin
                    w_state_nxt = ST_ZERO;
                end else if (tick && (r_cnt == c_LAST)) begin
                    w_state_nxt = ST_ONE;
                    w_rise_nxt  = 1'b1;
                end else if (tick) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_ONE: begin
                if (!w_sw_s) begin
                    w_state_nxt = ST_WAIT0;
                    w_cnt_nxt   = '0;
                end
            end
            ST_WAIT0: begin
                if (w_sw_s) begin
                    w_state_nxt = ST_ONE;
                end else if (tick && (r_cnt == c_LAST)) begin
                    w_state_nxt = ST_ZERO;
                    w_fall_nxt  = 1'b1;
                end else if (tick) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_ZERO;
                w_cnt_nxt   = '0;
            end
        endcase
        // Level and busy follow the state being entered so they register
        // on the same edge as the state itself
        w_level_nxt = (w_state_nxt == ST_ONE) || (w_state_nxt == ST_WAIT0);
        w_busy_nxt  = (w_state_nxt == ST_WAIT1) || (w_state_nxt == ST_WAIT0);
    end

    // State, counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_ZERO;
            r_cnt    <= '0;
            db_level <= 1'b0;
            db_rise  <= 1'b0;
            db_fall  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            db_level <= w_level_nxt;
            db_rise  <= w_rise_nxt;
            db_fall  <= w_fall_nxt;
            busy     <= w_busy_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_debounce_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce_fsm
// Description : Directed self-checking bench for debounce_fsm. Instance u_a
//               uses STABLE_TICKS=3, instance u_b uses STABLE_TICKS=1; both
//               share clock, reset, tick and sw.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_fsm;

`ifdef DEBOUNCE_SYNC_EN
    localparam int c_LAT = 2;
`else
    localparam int c_LAT = 0;
`endif

    logic clk;
    logic reset;
    logic tick;
    logic sw;
    logic db_level, db_rise, db_fall, busy;
    logic b_level, b_rise, b_fall, b_busy;

    int n_checks;
    int n_fail;
    int n_rise;
    int tick_period;
    int phase;
    bit last_tick;

    debounce_fsm #(.STABLE_TICKS(3)) u_a (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .sw       (sw),
        .db_level (db_level),
        .db_rise  (db_rise),
        .db_fall  (db_fall),
        .busy     (busy)
    );

    debounce_fsm #(.STABLE_TICKS(1)) u_b (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .sw       (sw),
        .db_level (b_level),
        .db_rise  (b_rise),
        .db_fall  (b_fall),
        .busy     (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock with an explicit tick value; outputs are sampled 1 ns after the edge
    task automatic step_t(input bit t);
        tick = t;
        last_tick = t;
        @(posedge clk);
        #1;
        if (db_rise) n_rise++;
    endtask

    // One clock with the free-running tick generator
    task automatic step();
        bit t;
        t = (tick_period != 0) && (phase == tick_period - 1);
        phase = (phase + 1 == tick_period) ? 0 : phase + 1;
        step_t(t);
    endtask

    // Let sw propagate through the optional synchronizer without ticking
    task automatic settle();
        for (int i = 0; i < c_LAT; i++) step_t(1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sw = 1'b0;
        step_t(1'b0);
        step_t(1'b0);
        reset = 1'b0;
        step_t(1'b0);
        step_t(1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sw = 1'b1;
        tick_period = 10;
        for (int i = 0; i < 3; i++) step();
        n_checks++; if (db_level !== 1'b0) begin n_fail++; $display("FAIL rst_level got=%b want=0", db_level); end
        n_checks++; if (db_rise !== 1'b0) begin n_fail++; $display("FAIL rst_rise got=%b want=0", db_rise); end
        n_checks++; if (db_fall !== 1'b0) begin n_fail++; $display("FAIL rst_fall got=%b want=0", db_fall); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b want=0", busy); end
        reset = 1'b0;
        phase = 0;
        n_rise = 0;
        for (int k = 1; k <= 32; k++) begin
            step();
            if (k == 1) begin
                n_checks++; if (db_level !== 1'b0 || db_rise !== 1'b0) begin n_fail++; $display("FAIL post_rst level/rise got=%b%b want=00", db_level, db_rise); end
            end
            if (k == 1 + c_LAT) begin
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rise_busy got=%b want=1", busy); end
            end
            if (k == 29) begin
                n_checks++; if (db_level !== 1'b0) begin n_fail++; $display("FAIL early_level got=%b want=0", db_level); end
            end
            if (k == 30) begin
                n_checks++; if (db_rise !== 1'b1 || db_level !== 1'b1) begin n_fail++; $display("FAIL rise_edge rise/level got=%b%b want=11", db_rise, db_level); end
            end
            if (k == 31) begin
                n_checks++; if (db_rise !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rise_once rise/busy got=%b%b want=00", db_rise, busy); end
            end
        end
        n_checks++; if (n_rise !== 1) begin n_fail++; $display("FAIL rise_count got=%0d want=1", n_rise); end
    endtask

    task automatic test_bounce();
        int ticks_seen;
        int rise_at;
        do_reset();
        tick_period = 10;
        phase = 0;
        n_rise = 0;
        for (int i = 0; i < 50; i++) begin
            sw = ((i / 3) % 2 == 0);
            step();
        end
        n_checks++; if (n_rise !== 0 || db_level !== 1'b0) begin n_fail++; $display("FAIL bounce_reject rises=%0d level=%b want 0,0", n_rise, db_level); end
        sw = 1'b1;
        ticks_seen = 0;
        rise_at = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (last_tick) ticks_seen++;
            if (db_rise && rise_at < 0) rise_at = ticks_seen;
        end
        n_checks++; if (n_rise !== 1) begin n_fail++; $display("FAIL bounce_rise_count got=%0d want=1", n_rise); end
        n_checks++; if (rise_at < 2 || rise_at > 3) begin n_fail++; $display("FAIL bounce_rise_ticks got=%0d want=2..3", rise_at); end
        n_checks++; if (db_level !== 1'b1) begin n_fail++; $display("FAIL bounce_level got=%b want=1", db_level); end
    endtask

    task automatic test_terminal_glitch();
        do_reset();
        tick_period = 0;
        n_rise = 0;
        sw = 1'b1;
        settle();
        step_t(1'b0);
        step_t(1'b1);
        step_t(1'b1);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_wait_busy got=%b want=1", busy); end
        sw = 1'b0;
        settle();
        step_t(1'b1);
        n_checks++; if (busy !== 1'b0 || db_level !== 1'b0 || db_rise !== 1'b0) begin n_fail++; $display("FAIL glitch_abort busy/level/rise got=%b%b%b want=000", busy, db_level, db_rise); end
        step_t(1'b1);
        n_checks++; if (n_rise !== 0 || db_level !== 1'b0) begin n_fail++; $display("FAIL glitch_no_rise rises=%0d level=%b want 0,0", n_rise, db_level); end
    endtask

    task automatic test_fall();
        sw = 1'b1;
        settle();
        step_t(1'b0);
        step_t(1'b1);
        step_t(1'b1);
        step_t(1'b1);
        n_checks++; if (db_level !== 1'b1 || db_rise !== 1'b1) begin n_fail++; $display("FAIL fall_setup level/rise got=%b%b want=11", db_level, db_rise); end
        sw = 1'b0;
        settle();
        step_t(1'b0);
        n_checks++; if (busy !== 1'b1 || db_level !== 1'b1) begin n_fail++; $display("FAIL fall_wait busy/level got=%b%b want=11", busy, db_level); end
        step_t(1'b1);
        step_t(1'b1);
        n_checks++; if (db_fall !== 1'b0 || db_level !== 1'b1) begin n_fail++; $display("FAIL fall_early fall/level got=%b%b want=01", db_fall, db_level); end
        step_t(1'b1);
        n_checks++; if (db_fall !== 1'b1 || db_level !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL fall_edge fall/level/busy got=%b%b%b want=100", db_fall, db_level, busy); end
        step_t(1'b1);
        n_checks++; if (db_fall !== 1'b0 || db_level !== 1'b0) begin n_fail++; $display("FAIL fall_once fall/level got=%b%b want=00", db_fall, db_level); end
    endtask

    task automatic test_reset_mid();
        sw = 1'b1;
        settle();
        step_t(1'b0);
        step_t(1'b1);
        step_t(1'b1);
        step_t(1'b1);
        sw = 1'b0;
        settle();
        step_t(1'b0);
        step_t(1'b1);
        step_t(1'b1);
        n_checks++; if (busy !== 1'b1 || db_level !== 1'b1) begin n_fail++; $display("FAIL mid_setup busy/level got=%b%b want=11", busy, db_level); end
        reset = 1'b1;
        step_t(1'b0);
        n_checks++; if (db_level !== 1'b0 || db_fall !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset level/fall/busy got=%b%b%b want=000", db_level, db_fall, busy); end
        reset = 1'b0;
        step_t(1'b1);
        step_t(1'b1);
        n_checks++; if (db_fall !== 1'b0 || db_level !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_after fall/level/busy got=%b%b%b want=000", db_fall, db_level, busy); end
    endtask

    task automatic test_single_tick();
        do_reset();
        tick_period = 0;
        step_t(1'b1);
        n_checks++; if (b_level !== 1'b0 || b_busy !== 1'b0) begin n_fail++; $display("FAIL st1_idle_tick level/busy got=%b%b want=00", b_level, b_busy); end
        sw = 1'b1;
        settle();
        step_t(1'b0);
        step_t(1'b0);
        step_t(1'b0);
        n_checks++; if (b_busy !== 1'b1 || b_level !== 1'b0 || u_b.r_cnt !== 1'b0) begin n_fail++; $display("FAIL st1_wait busy/level/cnt got=%b%b%b want=100", b_busy, b_level, u_b.r_cnt); end
        step_t(1'b1);
        n_checks++; if (b_rise !== 1'b1 || b_level !== 1'b1 || b_busy !== 1'b0) begin n_fail++; $display("FAIL st1_rise rise/level/busy got=%b%b%b want=110", b_rise, b_level, b_busy); end
        sw = 1'b0;
        settle();
        step_t(1'b0);
        step_t(1'b0);
        step_t(1'b0);
        n_checks++; if (b_busy !== 1'b1 || b_level !== 1'b1 || u_b.r_cnt !== 1'b0) begin n_fail++; $display("FAIL st1_wait0 busy/level/cnt got=%b%b%b want=110", b_busy, b_level, u_b.r_cnt); end
        step_t(1'b1);
        n_checks++; if (b_fall !== 1'b1 || b_level !== 1'b0) begin n_fail++; $display("FAIL st1_fall fall/level got=%b%b want=10", b_fall, b_level); end
    endtask

    // Watchdog so the run always ends even if a task stalls
    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail = 0;
        n_rise = 0;
        tick_period = 0;
        phase = 0;
        last_tick = 1'b0;
        tick = 1'b0;
        sw = 1'b0;
        reset = 1'b1;
        test_reset();
        test_bounce();
        test_terminal_glitch();
        test_fall();
        test_reset_mid();
        test_single_tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
